// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory bus between the MEM stage and data memory.
// The stage is the master (drives request fields); memory is the slave
// (answers with ready and read data).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage. Issues loads/stores on the data-memory
// bus, stalls the front of the pipe while memory is busy, aborts after
// MEM_TIMEOUT wait cycles, and registers the MEM/WB result.
//
// Build option: define MEM_SUBWORD_ACCESS_EN to enable byte/half accesses
// (i_size, i_unsigned). Without it every access is a word access.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access outstanding; requests are driven from the inputs
// ST_WAIT | request captured and held on the bus until ready or timeout
module mem_access_stage #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [31:0]        i_alu_result,
    input  logic [31:0]        i_mem_wr_data,
    input  logic [4:0]         i_rd,
    input  logic               i_reg_write,
    input  logic               i_mem_to_reg,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    output logic               o_stall,
    mem_access_stage_if.master dmem,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_data,
    output logic               wb_err
);

    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] SZ_WORD     = 2'b10;
    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        in_mem_op;
    logic        in_store;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic [31:0] in_load_data;

    logic        capture;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [4:0]  cap_rd;
    logic        cap_reg_write;
    logic        cap_mem_to_reg;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_load_data;

    logic        req;
    logic        stall;
    logic        wb_valid_d;
    logic        wb_reg_write_d;
    logic        wb_err_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_be = 4'b0001 << lo;
            SZ_HALF: lane_be = 4'b0011 << lo;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: lane_wdata = {4{data[7:0]}};
            SZ_HALF: lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        shifted = rdata >> {lo, 3'b000};
        case (size)
            SZ_BYTE: load_extract = uns ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_extract = uns ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_extract = rdata;
        endcase
    endfunction

`ifdef MEM_SUBWORD_ACCESS_EN
    assign in_size     = i_size;
    assign in_unsigned = i_unsigned;
`else
    // Word-only build: size/sign controls are deliberately ignored.
    logic unused_subword;
    assign in_size        = SZ_WORD;
    assign in_unsigned    = 1'b0;
    assign unused_subword = ^{i_size, i_unsigned};
`endif

    // Both read and write set is treated as a store.
    assign in_mem_op     = i_valid && (i_mem_read || i_mem_write);
    assign in_store      = i_mem_write;
    assign in_misaligned = is_misaligned(in_size, i_alu_result[1:0]);
    assign in_be         = lane_be(in_size, i_alu_result[1:0]);
    assign in_wdata      = lane_wdata(in_size, i_mem_wr_data);
    assign in_load_data  = load_extract(in_size, in_unsigned, i_alu_result[1:0], dmem.dmem_rdata);
    assign cap_load_data = load_extract(cap_size, cap_unsigned, cap_addr[1:0], dmem.dmem_rdata);

    // State and wait-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture on entry to ST_WAIT; contents only matter while waiting.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_addr       <= i_alu_result;
            cap_wdata      <= in_wdata;
            cap_be         <= in_be;
            cap_we         <= in_store;
            cap_rd         <= i_rd;
            cap_reg_write  <= i_reg_write;
            cap_mem_to_reg <= i_mem_to_reg;
            cap_size       <= in_size;
            cap_unsigned   <= in_unsigned;
        end
    end

    // Next state, stall, request and WB next values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req            = 1'b0;
        stall          = 1'b0;
        capture        = 1'b0;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_err_d       = 1'b0;
        wb_rd_d        = i_rd;
        wb_data_d      = i_alu_result;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (i_valid && !in_mem_op) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = i_reg_write;
                end else if (in_mem_op && in_misaligned) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                end else if (in_mem_op) begin
                    req = 1'b1;
                    if (dmem.dmem_ready) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = i_reg_write && !in_store;
                        if (i_mem_to_reg && !in_store) begin
                            wb_data_d = in_load_data;
                        end
                    end else begin
                        capture = 1'b1;
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req       = 1'b1;
                wb_rd_d   = cap_rd;
                wb_data_d = cap_addr;
                if (dmem.dmem_ready) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = cap_reg_write && !cap_we;
                    if (cap_mem_to_reg && !cap_we) begin
                        wb_data_d = cap_load_data;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM) begin
                    // Timeout: release the pipe this cycle and report an error.
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            req   = 1'b0;
            stall = 1'b0;
        end
    end

    // Bus fields come from the inputs when idle and from the capture while waiting.
    always_comb begin
        dmem.dmem_req = req;
        if (state_q == ST_WAIT) begin
            dmem.dmem_we    = cap_we;
            dmem.dmem_addr  = {cap_addr[31:2], 2'b00};
            dmem.dmem_wdata = cap_wdata;
            dmem.dmem_be    = cap_be;
        end else begin
            dmem.dmem_we    = in_store;
            dmem.dmem_addr  = {i_alu_result[31:2], 2'b00};
            dmem.dmem_wdata = in_wdata;
            dmem.dmem_be    = in_be;
        end
    end

    assign o_stall = stall;

    // MEM/WB register; stall cycles and empty slots load a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= 32'd0;
            wb_err       <= 1'b0;
        end else begin
            wb_valid     <= wb_valid_d;
            wb_reg_write <= wb_reg_write_d;
            wb_rd        <= wb_rd_d;
            wb_data      <= wb_data_d;
            wb_err       <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage (MEM_TIMEOUT=4).
// Subword cases follow MEM_SUBWORD_ACCESS_EN the same way the design does.
module tb_mem_access_stage;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        err;
        logic [31:0] data;
        bit          chk_data;
    } wb_exp_t;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_alu_result;
    logic [31:0] i_mem_wr_data;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        i_mem_to_reg;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic        o_stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    int n_chk;
    int n_err;
    wb_exp_t sb[$];
    wb_exp_t mon_e;

    mem_access_stage_if mem_bus ();

    mem_access_stage #(.MEM_TIMEOUT(4)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_alu_result (i_alu_result),
        .i_mem_wr_data(i_mem_wr_data),
        .i_rd         (i_rd),
        .i_reg_write  (i_reg_write),
        .i_mem_to_reg (i_mem_to_reg),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .o_stall      (o_stall),
        .dmem         (mem_bus),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic mr, input logic mw, input logic m2r,
                          input logic rw, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        i_valid       = v;
        i_mem_read    = mr;
        i_mem_write   = mw;
        i_mem_to_reg  = m2r;
        i_reg_write   = rw;
        i_size        = sz;
        i_unsigned    = uns;
        i_alu_result  = addr;
        i_mem_wr_data = wd;
        i_rd          = rd;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic rw, input logic err,
                           input logic [31:0] data, input bit chk_data);
        wb_exp_t e;
        e.rd       = rd;
        e.rw       = rw;
        e.err      = err;
        e.data     = data;
        e.chk_data = chk_data;
        sb.push_back(e);
    endtask

    // Called at posedge+1 with the op already on the inputs. Memory answers
    // ready once the request has seen ready_delay not-ready cycles.
    task automatic run_access(input string tag, input int ready_delay, input int exp_stalls,
                              input logic exp_req, input logic [31:0] exp_addr,
                              input logic exp_we, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic exp_wb);
        int  k;
        int  stalls;
        bit  done;
        k      = 0;
        stalls = 0;
        done   = 0;
        while (!done) begin
            mem_bus.dmem_ready = (k >= ready_delay);
            #3;
            chk({tag, "_req"}, 32'(mem_bus.dmem_req), 32'(exp_req));
            if (exp_req && k == 0) begin
                chk({tag, "_addr"}, mem_bus.dmem_addr, exp_addr);
                chk({tag, "_we"}, 32'(mem_bus.dmem_we), 32'(exp_we));
                if (exp_we) begin
                    chk({tag, "_be"}, 32'(mem_bus.dmem_be), 32'(exp_be));
                    chk({tag, "_wdata"}, mem_bus.dmem_wdata, exp_wdata);
                end
            end
            if (!o_stall) begin
                done = 1;
            end else begin
                stalls++;
            end
            if (k > 40) begin
                chk({tag, "_bound"}, 32'(k), 32'd40);
                done = 1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        i_valid            = 1'b0;
        mem_bus.dmem_ready = 1'b0;
        #3;
        chk({tag, "_wbv"}, 32'(wb_valid), 32'(exp_wb));
        @(posedge clk);
        #1;
    endtask

    // WB monitor: every valid result must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                chk("wb_rw", 32'(wb_reg_write), 32'(mon_e.rw));
                chk("wb_err", 32'(wb_err), 32'(mon_e.err));
                if (mon_e.chk_data) begin
                    chk("wb_data", wb_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        mem_bus.dmem_ready = 1'b0;
        mem_bus.dmem_rdata = 32'h0;
        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h100, 32'h0, 5'd1);

        // Reset: bus and stall forced low even with an op on the inputs.
        repeat (2) @(posedge clk);
        #1;
        #3;
        chk("rst_req", 32'(mem_bus.dmem_req), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbrw", 32'(wb_reg_write), 32'd0);
        chk("rst_wbrd", 32'(wb_rd), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_wberr", 32'(wb_err), 32'd0);
        @(posedge clk);
        #1;

        // lw 0x100, ready in the same cycle.
        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h100, 32'h0, 5'd5);
        mem_bus.dmem_rdata = 32'h1234_5678;
        push_wb(5'd5, 1, 0, 32'h1234_5678, 1);
        run_access("lw_fast", 0, 0, 1, 32'h100, 0, 4'hF, 32'h0, 1);

        // lw 0x104, two wait cycles.
        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h104, 32'h0, 5'd6);
        mem_bus.dmem_rdata = 32'hA5A5_0F0F;
        push_wb(5'd6, 1, 0, 32'hA5A5_0F0F, 1);
        run_access("lw_slow", 2, 2, 1, 32'h104, 0, 4'hF, 32'h0, 1);

        // lw 0x101 misaligned; ready offered anyway and must be ignored.
        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h101, 32'h0, 5'd7);
        push_wb(5'd7, 0, 1, 32'h0, 0);
        run_access("lw_mis", 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1);

        // Non-memory op passes the ALU result.
        set_op(1, 0, 0, 0, 1, SZ_WORD, 0, 32'hDEAD_0001, 32'h0, 5'd8);
        push_wb(5'd8, 1, 0, 32'hDEAD_0001, 1);
        run_access("alu", 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1);

        // Empty slot with memory controls set: nothing happens.
        set_op(0, 1, 0, 1, 1, SZ_WORD, 0, 32'h100, 32'h0, 5'd3);
        run_access("bubble", 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 0);

        // sw 0x200, one wait cycle.
        set_op(1, 0, 1, 0, 0, SZ_WORD, 0, 32'h200, 32'hCAFE_F00D, 5'd0);
        push_wb(5'd0, 0, 0, 32'h200, 1);
        run_access("sw", 1, 1, 1, 32'h200, 1, 4'hF, 32'hCAFE_F00D, 1);

        // Read and write both set behaves as a store.
        set_op(1, 1, 1, 0, 0, SZ_WORD, 0, 32'h208, 32'h1122_3344, 5'd9);
        push_wb(5'd9, 0, 0, 32'h208, 1);
        run_access("rw_store", 0, 0, 1, 32'h208, 1, 4'hF, 32'h1122_3344, 1);

`ifdef MEM_SUBWORD_ACCESS_EN
        // lb 0x103 signed, ready after three stall cycles.
        set_op(1, 1, 0, 1, 1, SZ_BYTE, 0, 32'h103, 32'h0, 5'd12);
        mem_bus.dmem_rdata = 32'h80FF_FF12;
        push_wb(5'd12, 1, 0, 32'hFFFF_FF80, 1);
        run_access("lb", 3, 3, 1, 32'h100, 0, 4'h0, 32'h0, 1);

        set_op(1, 1, 0, 1, 1, SZ_BYTE, 1, 32'h103, 32'h0, 5'd13);
        push_wb(5'd13, 1, 0, 32'h0000_0080, 1);
        run_access("lbu", 0, 0, 1, 32'h100, 0, 4'h0, 32'h0, 1);

        set_op(1, 1, 0, 1, 1, SZ_HALF, 0, 32'h102, 32'h0, 5'd14);
        push_wb(5'd14, 1, 0, 32'hFFFF_80FF, 1);
        run_access("lh", 0, 0, 1, 32'h100, 0, 4'h0, 32'h0, 1);

        set_op(1, 0, 1, 0, 0, SZ_HALF, 0, 32'h202, 32'h0000_BEEF, 5'd15);
        push_wb(5'd15, 0, 0, 32'h202, 1);
        run_access("sh", 0, 0, 1, 32'h200, 1, 4'b1100, 32'hBEEF_BEEF, 1);

        set_op(1, 0, 1, 0, 0, SZ_BYTE, 0, 32'h201, 32'h0000_00A5, 5'd16);
        push_wb(5'd16, 0, 0, 32'h201, 1);
        run_access("sb", 0, 0, 1, 32'h200, 1, 4'b0010, 32'hA5A5_A5A5, 1);

        set_op(1, 1, 0, 1, 1, SZ_HALF, 0, 32'h103, 32'h0, 5'd17);
        push_wb(5'd17, 0, 1, 32'h0, 0);
        run_access("lh_mis", 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1);
`else
        // Word-only build: size is ignored, so low address bits decide.
        set_op(1, 1, 0, 1, 1, SZ_BYTE, 0, 32'h103, 32'h0, 5'd12);
        push_wb(5'd12, 0, 1, 32'h0, 0);
        run_access("lb_word_mis", 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1);

        set_op(1, 1, 0, 1, 1, SZ_BYTE, 0, 32'h100, 32'h0, 5'd13);
        mem_bus.dmem_rdata = 32'h80FF_FF12;
        push_wb(5'd13, 1, 0, 32'h80FF_FF12, 1);
        run_access("lb_word", 0, 0, 1, 32'h100, 0, 4'h0, 32'h0, 1);

        set_op(1, 0, 1, 0, 0, SZ_HALF, 0, 32'h202, 32'h0000_BEEF, 5'd15);
        push_wb(5'd15, 0, 1, 32'h0, 0);
        run_access("sh_word_mis", 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1);

        set_op(1, 0, 1, 0, 0, SZ_BYTE, 0, 32'h204, 32'h0000_00A5, 5'd16);
        push_wb(5'd16, 0, 0, 32'h204, 1);
        run_access("sb_word", 0, 0, 1, 32'h204, 1, 4'hF, 32'h0000_00A5, 1);
`endif

        // Timeout: memory never ready; abort after 4 wait cycles.
        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h300, 32'h0, 5'd10);
        push_wb(5'd10, 0, 1, 32'h0, 0);
        run_access("tmo", 1000, 4, 1, 32'h300, 0, 4'h0, 32'h0, 1);

        // Back in idle: immediate completion without stall.
        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h304, 32'h0, 5'd11);
        mem_bus.dmem_rdata = 32'h0BAD_CAFE;
        push_wb(5'd11, 1, 0, 32'h0BAD_CAFE, 1);
        run_access("post_tmo", 0, 0, 1, 32'h304, 0, 4'h0, 32'h0, 1);

        // Reset pulsed while waiting abandons the access.
        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h400, 32'h0, 5'd18);
        mem_bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        i_valid = 1'b0;
        #3;
        chk("wrst_req_in", 32'(mem_bus.dmem_req), 32'd0);
        chk("wrst_stall_in", 32'(o_stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        chk("wrst_req", 32'(mem_bus.dmem_req), 32'd0);
        chk("wrst_stall", 32'(o_stall), 32'd0);
        chk("wrst_wbv", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;

        set_op(1, 1, 0, 1, 1, SZ_WORD, 0, 32'h404, 32'h0, 5'd19);
        mem_bus.dmem_rdata = 32'h55AA_55AA;
        push_wb(5'd19, 1, 0, 32'h55AA_55AA, 1);
        run_access("post_rst", 0, 0, 1, 32'h404, 0, 4'h0, 32'h0, 1);

        repeat (2) @(posedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 15, meaning the maximum number of WAIT cycles before an access is aborted (legal range 1..255).
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide inputs from the EX/MEM register:
- i_valid 1: slot holds an instruction.
- i_alu_result 32: address or ALU result.
- i_mem_wr_data 32: store data.
- i_rd 5: destination register.
- i_reg_write 1, i_mem_to_reg 1, i_mem_read 1, i_mem_write 1: control bits.
- i_size 2: 00 byte, 01 half, 10 word.
- i_unsigned 1: zero-extend loads.
REQ-005 SHALL provide o_stall  output  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers while high.
REQ-006 SHALL provide the data-memory port:
- dmem_req out 1, dmem_we out 1, dmem_addr out 32 (word-aligned), dmem_wdata out 32, dmem_be out 4.
- dmem_ready in 1, dmem_rdata in 32.
REQ-007 SHALL provide registered MEM/WB outputs: wb_valid 1, wb_reg_write 1, wb_rd 5, wb_data 32, wb_err 1.

Function
REQ-008 SHALL implement FSM states IDLE and WAIT, where a memory op is i_valid && (i_mem_read || i_mem_write).
REQ-009 In IDLE with an aligned memory op, dmem_req SHALL be driven combinationally from the inputs in the same cycle.
REQ-010 In IDLE with an aligned memory op, if dmem_ready=1 the access SHALL complete that cycle with o_stall=0; otherwise the request fields SHALL be captured, the FSM SHALL enter WAIT, and o_stall SHALL be 1.
REQ-011 In WAIT, dmem_req SHALL be held at 1 with the captured fields, independent of the inputs.
REQ-012 In WAIT, o_stall SHALL be !dmem_ready; on dmem_ready=1 the access SHALL complete and the FSM SHALL return to IDLE.
REQ-013 In WAIT, a counter SHALL increment each non-ready cycle; on reaching MEM_TIMEOUT the access SHALL abort with wb_valid=1, wb_err=1 and wb_reg_write=0, the FSM SHALL return to IDLE, and o_stall SHALL drop in that same cycle.
REQ-014 A completed access or a non-memory op SHALL load the WB registers at the next edge with latency 1 cycle and wb_valid=1.
REQ-015 wb_data SHALL be the extracted load data when i_mem_to_reg=1, else the ALU result.
REQ-016 For loads, the byte or half SHALL be selected by addr[1:0] and extended: sign-extended when i_unsigned=0, zero-extended when i_unsigned=1.
REQ-017 For stores, the data SHALL be replicated across lanes, with dmem_be=0001<<addr[1:0] for a byte, 0011<<addr[1:0] for a half, and 1111 for a word.
REQ-018 A misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL issue no dmem_req and no stall, and SHALL produce wb_valid=1, wb_err=1, wb_reg_write=0 one cycle later.
REQ-019 In a stall cycle, or when i_valid=0, the WB registers SHALL load a bubble: wb_valid=0, wb_reg_write=0, wb_err=0.
REQ-020 When i_mem_read and i_mem_write are both set, the instruction SHALL be treated as a store.
REQ-021 dmem_ready asserted while dmem_req=0 SHALL be ignored.

Reset
REQ-022 On reset at a rising edge, state SHALL become IDLE, the counter 0, and wb_valid, wb_reg_write, wb_rd, wb_data and wb_err all 0.
REQ-023 While reset=1, dmem_req and o_stall SHALL be forced to 0.
REQ-024 Reset asserted in WAIT SHALL abandon the access with no WB write.

Configuration
REQ-025 With MEM_SUBWORD_ACCESS_EN defined, the block SHALL honour i_size and i_unsigned as specified in REQ-016, REQ-017 and REQ-018.
REQ-026 With MEM_SUBWORD_ACCESS_EN undefined, i_size and i_unsigned SHALL be ignored, every access SHALL be a word access with dmem_be=1111, and addr[1:0]!=0 SHALL be misaligned.

Verification
REQ-027 The bench SHALL cover: lw at 0x100 with dmem_ready=1 in the same cycle -> no stall; next cycle wb_valid=1, wb_data=dmem_rdata.
REQ-028 The bench SHALL cover: lb at 0x103 with unsigned=0, rdata=0x80FF_FF12, ready after 3 cycles -> o_stall high for 3 cycles; wb_data=0xFFFF_FF80.
REQ-029 The bench SHALL cover: sh at 0x202 with data 0x0000_BEEF -> dmem_be=1100 and dmem_wdata=0xBEEF_BEEF; wb_reg_write=0.
REQ-030 The bench SHALL cover: lw at 0x101 -> dmem_req never asserted; one cycle later wb_err=1 and wb_reg_write=0.
REQ-031 The bench SHALL cover: MEM_TIMEOUT=4 with dmem_ready held at 0 -> abort after 4 WAIT cycles, wb_err=1, FSM back in IDLE.
REQ-032 The bench SHALL cover: reset pulsed during WAIT -> next cycle dmem_req=0, o_stall=0, wb_valid=0.
